// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the two result producers (ALU, load unit) and the
// register-file write arbiter. The arbiter uses the slave modport.
interface rf_wb_arbiter_if;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [4:0]  alu_adr_i;
  logic [31:0] alu_wd_i;

  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_adr_i;
  logic [31:0] lsu_wd_i;

  logic        rf_we_o;
  logic [4:0]  rf_adr_o;
  logic [31:0] rf_wd_o;
  logic [31:0] pending_o;

  modport slave (
    input  alu_valid_i, alu_adr_i, alu_wd_i,
    input  lsu_valid_i, lsu_adr_i, lsu_wd_i,
    output alu_ready_o, lsu_ready_o,
    output rf_we_o, rf_adr_o, rf_wd_o, pending_o
  );

  modport master (
    output alu_valid_i, alu_adr_i, alu_wd_i,
    output lsu_valid_i, lsu_adr_i, lsu_wd_i,
    input  alu_ready_o, lsu_ready_o,
    input  rf_we_o, rf_adr_o, rf_wd_o, pending_o
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: one DEPTH-entry FIFO per requester
// (index 0 = ALU, 1 = LSU), one grant per cycle into a registered write stage.
// Default arbitration is fixed priority (LSU first). Defining RF_WB_RR_EN
// selects round-robin between the two FIFO heads.
// pending_o flags every register with a queued or in-flight write so the
// issuing core can interlock; writes to r0 are drained silently.
module rf_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          nreset_i,
  rf_wb_arbiter_if.slave wb
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [4:0]  adr;
    logic [31:0] wd;
  } entry_t;

  entry_t               mem_q [2][DEPTH];
  entry_t               mem_d [2][DEPTH];
  logic [DEPTH-1:0]     vld_q [2];
  logic [DEPTH-1:0]     vld_d [2];
  logic [AW-1:0]        rd_q  [2];
  logic [AW-1:0]        rd_d  [2];
  logic [AW-1:0]        wr_q  [2];
  logic [AW-1:0]        wr_d  [2];

  logic                 last_grant_q, last_grant_d;
  logic                 we_q, we_d;
  logic [4:0]           adr_q, adr_d;
  logic [31:0]          wd_q, wd_d;
  // Held low through reset so both ready_o rise only on the first edge after release.
  logic                 rdy_en_q, rdy_en_d;

  logic [1:0]           in_vld;
  entry_t               in_ent [2];
  logic [1:0]           rdy;
  logic [1:0]           head_vld;
  logic                 gnt_any;
  logic                 gnt_sel;
  entry_t               head_ent;
  logic [31:0]          pend;

  assign in_vld[0] = wb.alu_valid_i;
  assign in_vld[1] = wb.lsu_valid_i;
  assign in_ent[0] = '{adr: wb.alu_adr_i, wd: wb.alu_wd_i};
  assign in_ent[1] = '{adr: wb.lsu_adr_i, wd: wb.lsu_wd_i};

  // Ready depends only on occupancy; entries are contiguous so full = all valid.
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      rdy[r]      = rdy_en_q & ~(&vld_q[r]);
      head_vld[r] = vld_q[r][rd_q[r]];
    end
  end

  // Arbitration between the two FIFO heads.
  always_comb begin
    gnt_any = head_vld[0] | head_vld[1];
`ifdef RF_WB_RR_EN
    if (head_vld[0] && head_vld[1]) begin
      gnt_sel = ~last_grant_q;
    end else begin
      gnt_sel = head_vld[1];
    end
`else
    gnt_sel = head_vld[1];
`endif
    head_ent = mem_q[gnt_sel][rd_q[gnt_sel]];
  end

  // Next state: pop the granted head into the write stage, then apply pushes.
  always_comb begin
    mem_d        = mem_q;
    vld_d        = vld_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    last_grant_d = last_grant_q;
    we_d         = 1'b0;
    adr_d        = adr_q;
    wd_d         = wd_q;
    rdy_en_d     = 1'b1;

    if (gnt_any) begin
      vld_d[gnt_sel][rd_q[gnt_sel]] = 1'b0;
      rd_d[gnt_sel]                 = rd_q[gnt_sel] + 1'b1;
      last_grant_d                  = gnt_sel;
      // r0 writes are consumed here but leave the write port untouched.
      if (head_ent.adr != 5'd0) begin
        we_d  = 1'b1;
        adr_d = head_ent.adr;
        wd_d  = head_ent.wd;
      end
    end

    // When a FIFO is neither empty nor full, wr and rd point at different slots.
    for (int r = 0; r < 2; r++) begin
      if (in_vld[r] && rdy[r]) begin
        mem_d[r][wr_q[r]] = in_ent[r];
        vld_d[r][wr_q[r]] = 1'b1;
        wr_d[r]           = wr_q[r] + 1'b1;
      end
    end
  end

  // State registers; reset discards all queued and in-flight writes.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      for (int r = 0; r < 2; r++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[r][i] <= '0;
        end
        vld_q[r] <= '0;
        rd_q[r]  <= '0;
        wr_q[r]  <= '0;
      end
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      adr_q        <= 5'd0;
      wd_q         <= 32'd0;
      rdy_en_q     <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      vld_q        <= vld_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      wd_q         <= wd_d;
      rdy_en_q     <= rdy_en_d;
    end
  end

  // Scoreboard of registers with writes queued or on the write port.
  always_comb begin
    pend = '0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[r][i]) begin
          pend[mem_q[r][i].adr] = 1'b1;
        end
      end
    end
    if (we_q) begin
      pend[adr_q] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  assign wb.alu_ready_o = rdy[0];
  assign wb.lsu_ready_o = rdy[1];
  assign wb.rf_we_o     = we_q;
  assign wb.rf_adr_o    = adr_q;
  assign wb.rf_wd_o     = wd_q;
  assign wb.pending_o   = pend;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (DEPTH = 2). Each vector record holds the
// inputs for one cycle plus the outputs expected before that cycle's edge.
module tb_rf_wb_arbiter;

  logic clk_i;
  logic nreset_i;

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter #(.DEPTH(2)) dut (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .wb       (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] aw;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] lw;
    logic        e_ar;
    logic        e_lr;
    logic        e_we;
    logic [4:0]  e_adr;
    logic [31:0] e_wd;
    logic [31:0] e_pend;
  } vec_t;

  vec_t tbl [$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic add(input logic av, input logic [4:0] aa, input logic [31:0] aw,
                     input logic lv, input logic [4:0] la, input logic [31:0] lw,
                     input logic ar, input logic lr, input logic we,
                     input logic [4:0] adr, input logic [31:0] wd, input logic [31:0] pend);
    vec_t v;
    v = '{av: av, aa: aa, aw: aw, lv: lv, la: la, lw: lw,
          e_ar: ar, e_lr: lr, e_we: we, e_adr: adr, e_wd: wd, e_pend: pend};
    tbl.push_back(v);
  endtask

  task automatic cmp(input string tag, input string fld, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s %s: got %h expected %h", tag, fld, act, exp);
      n_miss++;
    end
  endtask

  task automatic chk(input string tag, input logic ar, input logic lr, input logic we,
                     input logic [4:0] adr, input logic [31:0] wd, input logic [31:0] pend);
    n_vec++;
    cmp(tag, "alu_ready_o", {31'd0, bus.alu_ready_o}, {31'd0, ar});
    cmp(tag, "lsu_ready_o", {31'd0, bus.lsu_ready_o}, {31'd0, lr});
    cmp(tag, "rf_we_o",     {31'd0, bus.rf_we_o},     {31'd0, we});
    cmp(tag, "rf_adr_o",    {27'd0, bus.rf_adr_o},    {27'd0, adr});
    cmp(tag, "rf_wd_o",     bus.rf_wd_o,              wd);
    cmp(tag, "pending_o",   bus.pending_o,            pend);
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] aw,
                       input logic lv, input logic [4:0] la, input logic [31:0] lw);
    bus.alu_valid_i = av;
    bus.alu_adr_i   = aa;
    bus.alu_wd_i    = aw;
    bus.lsu_valid_i = lv;
    bus.lsu_adr_i   = la;
    bus.lsu_wd_i    = lw;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    nreset_i = 1'b0;

    //    alu v adr wd              lsu v adr wd               ar lr we adr wd            pending
    add(1, 5'd5,  32'hDEADBEEF,  0, 5'd0,  32'h0,         1, 1, 0, 5'd0,  32'h0,        32'h0);
    add(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         1, 1, 0, 5'd0,  32'h0,        32'h20);
    add(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         1, 1, 1, 5'd5,  32'hDEADBEEF, 32'h20);
    add(1, 5'd3,  32'h33,        1, 5'd7,  32'h77,        1, 1, 0, 5'd5,  32'hDEADBEEF, 32'h0);
    add(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         1, 1, 0, 5'd5,  32'hDEADBEEF, 32'h88);
    add(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         1, 1, 1, 5'd7,  32'h77,       32'h88);
    add(0, 5'd0,  32'h0,         1, 5'd0,  32'h12345678,  1, 1, 1, 5'd3,  32'h33,       32'h08);
    add(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         1, 1, 0, 5'd3,  32'h33,       32'h0);
`ifndef RF_WB_RR_EN
    add(1, 5'd1,  32'h101,       1, 5'd10, 32'hA0,        1, 1, 0, 5'd3,  32'h33,       32'h0);
    add(1, 5'd2,  32'h102,       1, 5'd11, 32'hA1,        1, 1, 0, 5'd3,  32'h33,       32'h402);
    add(1, 5'd4,  32'h104,       1, 5'd12, 32'hA2,        0, 1, 1, 5'd10, 32'hA0,       32'hC06);
    add(1, 5'd4,  32'h104,       0, 5'd0,  32'h0,         0, 1, 1, 5'd11, 32'hA1,       32'h1806);
    add(1, 5'd4,  32'h104,       0, 5'd0,  32'h0,         0, 1, 1, 5'd12, 32'hA2,       32'h1006);
    add(1, 5'd4,  32'h104,       0, 5'd0,  32'h0,         1, 1, 1, 5'd1,  32'h101,      32'h6);
    add(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         1, 1, 1, 5'd2,  32'h102,      32'h14);
    add(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         1, 1, 1, 5'd4,  32'h104,      32'h10);
    add(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         1, 1, 0, 5'd4,  32'h104,      32'h0);
`endif

    // Reset state, and ready held low after release until the first edge.
    repeat (2) @(negedge clk_i);
    #1 chk("reset", 0, 0, 0, 5'd0, 32'h0, 32'h0);
    @(negedge clk_i);
    nreset_i = 1'b1;
    #1 chk("release_pre_edge", 0, 0, 0, 5'd0, 32'h0, 32'h0);
    @(posedge clk_i);

    foreach (tbl[i]) begin
      @(negedge clk_i);
      drive(tbl[i].av, tbl[i].aa, tbl[i].aw, tbl[i].lv, tbl[i].la, tbl[i].lw);
      #1 chk($sformatf("vec%0d", i), tbl[i].e_ar, tbl[i].e_lr, tbl[i].e_we,
             tbl[i].e_adr, tbl[i].e_wd, tbl[i].e_pend);
    end
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0);

    // Simultaneous push from both requesters straight after reset.
    nreset_i = 1'b0;
    #1 chk("both_reset", 0, 0, 0, 5'd0, 32'h0, 32'h0);
    @(negedge clk_i);
    nreset_i = 1'b1;
    @(negedge clk_i);
    drive(1, 5'd3, 32'h333, 1, 5'd7, 32'h777);
    #1 chk("both_idle", 1, 1, 0, 5'd0, 32'h0, 32'h0);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("both_queued", 1, 1, 0, 5'd0, 32'h0, 32'h88);
    @(negedge clk_i);
`ifdef RF_WB_RR_EN
    #1 chk("both_first", 1, 1, 1, 5'd3, 32'h333, 32'h88);
    @(negedge clk_i);
    #1 chk("both_second", 1, 1, 1, 5'd7, 32'h777, 32'h80);
    @(negedge clk_i);
    #1 chk("both_done", 1, 1, 0, 5'd7, 32'h777, 32'h0);
`else
    #1 chk("both_first", 1, 1, 1, 5'd7, 32'h777, 32'h88);
    @(negedge clk_i);
    #1 chk("both_second", 1, 1, 1, 5'd3, 32'h333, 32'h08);
    @(negedge clk_i);
    #1 chk("both_done", 1, 1, 0, 5'd3, 32'h333, 32'h0);
`endif

    // Load up both FIFOs, then pulse reset in the middle of a cycle.
    @(negedge clk_i);
    drive(1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
    repeat (3) @(negedge clk_i);
`ifndef RF_WB_RR_EN
    #1 chk("loaded", 0, 1, 1, 5'd2, 32'h2, 32'h6);
`endif
    @(posedge clk_i);
    #2 nreset_i = 1'b0;
    #1 chk("async_reset", 0, 0, 0, 5'd0, 32'h0, 32'h0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    nreset_i = 1'b1;
    #1 chk("async_release", 0, 0, 0, 5'd0, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      #1 chk($sformatf("post_reset%0d", k), 1, 1, 0, 5'd0, 32'h0, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, entries per requester writeback queue (power of two, >= 2).
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port nreset_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports alu_valid_i input 1, alu_ready_o output 1, alu_adr_i input 5, alu_wd_i input 32: ALU writeback request, valid/ready handshake.
REQ-005 SHALL have ports lsu_valid_i input 1, lsu_ready_o output 1, lsu_adr_i input 5, lsu_wd_i input 32: load-unit writeback request, valid/ready handshake.
REQ-006 SHALL have ports rf_we_o output 1, rf_adr_o output 5, rf_wd_o output 32: register-file write port, driving we_i/adr3_i/wd3_i.
REQ-007 SHALL have port pending_o  output  32  bit r set while any write to register r is queued or in the output stage.

Function
REQ-008 SHALL accept a request on a rising edge where valid and ready are both 1; transfer pushes {adr, wd} into that requester's FIFO.
REQ-009 SHALL drive each ready_o = 1 iff its FIFO holds fewer than DEPTH entries; ready_o SHALL not depend on the same-cycle valid or grant.
REQ-010 SHALL, each cycle, grant at most one non-empty FIFO head, pop it, and load it into the output stage.
REQ-011 SHALL assert rf_we_o, with rf_adr_o/rf_wd_o from the popped entry, for exactly one cycle, starting the cycle after the pop (latency accept->rf_we_o min 2 cycles).
REQ-012 SHALL hold rf_we_o = 0 in cycles with no grant; rf_adr_o/rf_wd_o SHALL retain their last values.
REQ-013 SHALL accept and pop entries with adr = 0 normally but never assert rf_we_o for them.
REQ-014 SHALL allow push and pop on the same FIFO in one cycle, occupancy unchanged; a full FIFO SHALL accept no push.
REQ-015 SHALL preserve FIFO order per requester; FIFO pointers SHALL wrap modulo DEPTH.
REQ-016 SHALL compute pending_o combinationally as the OR of one-hot decodes of all valid FIFO entries plus the output stage when rf_we_o = 1, excluding address 0.
REQ-017 SHALL not order writes to the same register across requesters; the issuing core SHALL interlock on pending_o.
REQ-018 SHALL keep a 1-bit last_grant register (0 = ALU, 1 = LSU), updated on every grant.

Reset
REQ-019 SHALL, while nreset_i = 0, immediately empty both FIFOs, force rf_we_o = 0, rf_adr_o = 0, rf_wd_o = 0, pending_o = 0, last_grant = 1, and drive both ready_o = 0.
REQ-020 SHALL discard queued and in-flight writes on reset mid-operation, with no rf_we_o pulse after reset assertion.
REQ-021 SHALL raise both ready_o on the first rising edge after nreset_i deasserts.

Configuration
REQ-022 SHALL, with macro RF_WB_RR_EN defined, arbitrate round-robin: when both heads are valid, grant the requester not equal to last_grant; with one valid head, grant it.
REQ-023 SHALL, without RF_WB_RR_EN, use fixed priority: LSU head granted whenever valid, ALU only when LSU FIFO is empty; last_grant still updates.

Verification
REQ-024 SHALL pass: single ALU push adr=5 wd=0xDEADBEEF into idle block -> rf_we_o=1, rf_adr_o=5, rf_wd_o=0xDEADBEEF exactly 2 cycles after accept; pending_o[5]=1 from accept until the end of that cycle.
REQ-025 SHALL pass: ALU and LSU push adr=3/adr=7 on the same edge after reset -> with RF_WB_RR_EN, ALU write (adr 3) then LSU write (adr 7) on consecutive cycles; without it, LSU first.
REQ-026 SHALL pass: ALU pushes 3 entries (adr 1,2,4) back-to-back while LSU floods, DEPTH=2, fixed priority -> alu_ready_o=0 after 2 accepts, ALU writes stall until LSU FIFO empties, then issue in order 1,2,4.
REQ-027 SHALL pass: LSU push adr=0 wd=0x12345678 -> entry popped, lsu_ready_o recovers, rf_we_o stays 0, pending_o stays 0.
REQ-028 SHALL pass: both FIFOs full, nreset_i pulsed low mid-cycle -> rf_we_o, pending_o, ready_o drop to 0 without waiting for a clock edge; no rf_we_o after release; ready_o=1 on first edge after release.
